// File: rtl/fifo_ctrl_pkg.sv
// Shared definitions for the FIFO access arbiter.
//   state_t      : controller FSM states
//   PORT_A/B     : requester ids; also the bit index of that port in packed
//                  per-port vectors
//   OP_POP/PUSH  : op encoding carried on x_push
package fifo_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_HOLD  = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  localparam logic PORT_A  = 1'b0;
  localparam logic PORT_B  = 1'b1;

  localparam logic OP_POP  = 1'b0;
  localparam logic OP_PUSH = 1'b1;

endpackage

// File: rtl/fifo_regfile.sv
// DEPTH x WIDTH storage array for the shared FIFO.
//   clk     : write clock, rising edge
//   we      : write enable
//   waddr   : write address
//   wdata   : write data
//   raddr   : read address
//   rdata_c : combinational read data for raddr
module fifo_regfile #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata_c
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Storage carries no reset; valid contents are tracked by the controller.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata_c = mem[raddr];

endmodule

// File: rtl/fifo_access_arbiter.sv
// Round-robin arbiter sharing one FIFO between requesters A and B.
// One op (push or pop) commits per clock. Owns pointers, occupancy and flags.
//   myclock, resetn        : clock / async active-low reset
//   hold                   : suspend all grants while high
//   flush                  : 1-cycle pulse, discard contents and clear stickies
//   x_req/x_push/x_wdata   : port x op request (x = a, b)
//   x_gnt                  : op commits at this edge (combinational)
//   x_err                  : pulse after a rejected op (full push / empty pop)
//   x_rvalid               : pulse, rdata holds the word popped by port x
//   rdata                  : registered popped word, shared by both ports
//   count, empty, full     : occupancy 0..DEPTH and derived flags
//   ovf_sticky, unf_sticky : rejected push / pop seen since reset or flush
module fifo_access_arbiter
  import fifo_ctrl_pkg::*;
#(
  parameter  int DEPTH = 16,
  parameter  int WIDTH = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             myclock,
  input  logic             resetn,
  input  logic             hold,
  input  logic             flush,
  input  logic             a_req,
  input  logic             a_push,
  input  logic [WIDTH-1:0] a_wdata,
  output logic             a_gnt,
  output logic             a_err,
  output logic             a_rvalid,
  input  logic             b_req,
  input  logic             b_push,
  input  logic [WIDTH-1:0] b_wdata,
  output logic             b_gnt,
  output logic             b_err,
  output logic             b_rvalid,
  output logic [WIDTH-1:0] rdata,
  output logic [AW:0]      count,
  output logic             empty,
  output logic             full,
  output logic             ovf_sticky,
  output logic             unf_sticky
);

  state_t state, state_nxt;
  logic   arb_en;

  logic [1:0]            req_v, push_v, gnt_v, err_q, rvalid_q;
  logic [1:0][WIDTH-1:0] wdata_v;
  logic                  last_gnt, sel, op_valid, op_push;
  logic                  do_write, do_read, op_rej;
  logic [WIDTH-1:0]      op_wdata, rdata_c;
  logic [AW-1:0]         wptr, rptr;

  assign req_v   = {b_req,   a_req};
  assign push_v  = {b_push,  a_push};
  assign wdata_v = {b_wdata, a_wdata};

  // ---------------- FSM ----------------
  always_ff @(posedge myclock or negedge resetn) begin
    if (!resetn) state <= ST_RUN;
    else         state <= state_nxt;
  end

  // flush wins over hold from every state
  always_comb begin
    state_nxt = state;
    if (flush)     state_nxt = ST_FLUSH;
    else if (hold) state_nxt = ST_HOLD;
    else           state_nxt = ST_RUN;
  end

  always_comb begin
    arb_en = (state == ST_RUN);
  end

  // ---------------- arbitration ----------------
  // Live hold/flush also gate grants so a grant never lands in the cycle
  // hold rises or on a flush edge (that op is squashed).
  always_comb begin
    gnt_v = '0;
    if (arb_en && !hold && !flush) begin
      if (&req_v) gnt_v = (last_gnt == PORT_B) ? 2'b01 : 2'b10;
      else        gnt_v = req_v;
    end
  end

  assign a_gnt    = gnt_v[PORT_A];
  assign b_gnt    = gnt_v[PORT_B];
  assign sel      = gnt_v[PORT_B];
  assign op_valid = |gnt_v;
  assign op_push  = push_v[sel];
  assign op_wdata = wdata_v[sel];

  assign empty    = (count == '0);
  assign full     = (count == (AW+1)'(DEPTH));
  assign do_write = op_valid && (op_push == OP_PUSH) && !full;
  assign do_read  = op_valid && (op_push == OP_POP)  && !empty;
  assign op_rej   = op_valid && ((op_push == OP_PUSH) ? full : empty);

  // ---------------- storage ----------------
  fifo_regfile #(.DEPTH(DEPTH), .WIDTH(WIDTH), .AW(AW)) u_regfile (
    .clk     (myclock),
    .we      (do_write),
    .waddr   (wptr),
    .wdata   (op_wdata),
    .raddr   (rptr),
    .rdata_c (rdata_c)
  );

  // ---------------- pointers, count, status ----------------
  always_ff @(posedge myclock or negedge resetn) begin
    if (!resetn) begin
      wptr       <= '0;
      rptr       <= '0;
      count      <= '0;
      last_gnt   <= PORT_B;
      rdata      <= '0;
      err_q      <= '0;
      rvalid_q   <= '0;
      ovf_sticky <= 1'b0;
      unf_sticky <= 1'b0;
    end else begin
      // gnt_v is zero whenever flush is high, so these clear on a flush edge
      err_q    <= gnt_v & {2{op_rej}};
      rvalid_q <= gnt_v & {2{do_read}};
      if (op_valid) last_gnt <= sel;

      if (flush) begin
        wptr       <= '0;
        rptr       <= '0;
        count      <= '0;
        ovf_sticky <= 1'b0;
        unf_sticky <= 1'b0;
      end else begin
        if (do_write) begin
          wptr  <= wptr + 1'b1;
          count <= count + 1'b1;
        end
        if (do_read) begin
          rdata <= rdata_c;
          rptr  <= rptr + 1'b1;
          count <= count - 1'b1;
        end
        if (op_rej && (op_push == OP_PUSH)) ovf_sticky <= 1'b1;
        if (op_rej && (op_push == OP_POP))  unf_sticky <= 1'b1;
      end
    end
  end

  assign a_err    = err_q[PORT_A];
  assign b_err    = err_q[PORT_B];
  assign a_rvalid = rvalid_q[PORT_A];
  assign b_rvalid = rvalid_q[PORT_B];

endmodule

// File: tb/tb_fifo_access_arbiter.sv
module tb_fifo_access_arbiter;

  localparam int DEPTH = 16;
  localparam int WIDTH = 8;
  localparam int AW    = 4;

  logic             myclock, resetn, hold, flush;
  logic             a_req, a_push, a_gnt, a_err, a_rvalid;
  logic             b_req, b_push, b_gnt, b_err, b_rvalid;
  logic [WIDTH-1:0] a_wdata, b_wdata, rdata;
  logic [AW:0]      count;
  logic             empty, full, ovf_sticky, unf_sticky;

  typedef struct {
    logic             port;
    logic [WIDTH-1:0] data;
  } exp_t;

  exp_t             exp_q[$];
  logic [WIDTH-1:0] model[$];
  logic             ovf_exp, unf_exp;
  int               total, bad;

  fifo_access_arbiter #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .myclock(myclock), .resetn(resetn), .hold(hold), .flush(flush),
    .a_req(a_req), .a_push(a_push), .a_wdata(a_wdata),
    .a_gnt(a_gnt), .a_err(a_err), .a_rvalid(a_rvalid),
    .b_req(b_req), .b_push(b_push), .b_wdata(b_wdata),
    .b_gnt(b_gnt), .b_err(b_err), .b_rvalid(b_rvalid),
    .rdata(rdata), .count(count), .empty(empty), .full(full),
    .ovf_sticky(ovf_sticky), .unf_sticky(unf_sticky)
  );

  initial begin
    myclock = 0;
    forever #5 myclock = ~myclock;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  // One op on port p, called at a falling edge; returns at a falling edge
  // after checking the response pulses against the bench model.
  task automatic op(input logic p, input logic push, input logic [WIDTH-1:0] d);
    logic granted, rej, rv, er;
    exp_t e;
    granted = 0;
    if (p == 0) begin a_req = 1; a_push = push; a_wdata = d; end
    else        begin b_req = 1; b_push = push; b_wdata = d; end
    for (int i = 0; i < 40 && !granted; i++) begin
      #1;
      granted = p ? b_gnt : a_gnt;
      if (!granted) @(negedge myclock);
    end
    total++;
    if (!granted) begin
      bad++;
      $display("FAIL op_gnt port=%0d got=0 want=1", p);
      a_req = 0; b_req = 0;
      return;
    end
    rej = push ? (model.size() == DEPTH) : (model.size() == 0);
    if (push && !rej) model.push_back(d);
    if (!push && !rej) begin
      e.port = p; e.data = model.pop_front(); exp_q.push_back(e);
    end
    if (rej && push)  ovf_exp = 1;
    if (rej && !push) unf_exp = 1;
    @(posedge myclock);
    @(negedge myclock);
    if (p == 0) a_req = 0; else b_req = 0;
    er = p ? b_err : a_err;
    rv = p ? b_rvalid : a_rvalid;
    total++;
    if (er !== rej) begin bad++; $display("FAIL op_err port=%0d got=%b want=%b", p, er, rej); end
    total++;
    if (rv !== (!push && !rej)) begin bad++; $display("FAIL op_rvalid port=%0d got=%b want=%b", p, rv, !push && !rej); end
    if (rv === 1'b1) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++; $display("FAIL sb_underrun got rdata=%h want none", rdata);
      end else begin
        e = exp_q.pop_front();
        if (rdata !== e.data || e.port !== p) begin
          bad++; $display("FAIL sb_rdata port=%0d got=%h want=%h (port %0d)", p, rdata, e.data, e.port);
        end
      end
    end
    total++;
    if (count !== (AW+1)'(model.size()) || empty !== (model.size() == 0) || full !== (model.size() == DEPTH)) begin
      bad++; $display("FAIL op_count got=%0d/e%b/f%b want=%0d", count, empty, full, model.size());
    end
    total++;
    if ({ovf_sticky, unf_sticky} !== {ovf_exp, unf_exp}) begin
      bad++; $display("FAIL op_sticky got=%b%b want=%b%b", ovf_sticky, unf_sticky, ovf_exp, unf_exp);
    end
  endtask

  task automatic test_reset();
    @(negedge myclock);
    resetn = 0; hold = 0; flush = 0;
    a_req = 0; a_push = 0; a_wdata = '0;
    b_req = 0; b_push = 0; b_wdata = '0;
    model.delete(); exp_q.delete(); ovf_exp = 0; unf_exp = 0;
    repeat (2) @(negedge myclock);
    #1;
    total++;
    if ({count, empty, full, ovf_sticky, unf_sticky} !== {5'd0, 1'b1, 1'b0, 1'b0, 1'b0}) begin
      bad++; $display("FAIL reset_status got cnt=%0d e=%b f=%b o=%b u=%b", count, empty, full, ovf_sticky, unf_sticky);
    end
    total++;
    if ({rdata, a_err, b_err, a_rvalid, b_rvalid, a_gnt, b_gnt} !== {8'h00, 6'b0}) begin
      bad++; $display("FAIL reset_outputs got rdata=%h pulses=%b%b%b%b%b%b want 0", rdata, a_err, b_err, a_rvalid, b_rvalid, a_gnt, b_gnt);
    end
    @(negedge myclock);
    resetn = 1;
    @(negedge myclock);
  endtask

  task automatic test_basic();
    op(0, 1, 8'h11); op(0, 1, 8'h22); op(0, 1, 8'h33);
    op(0, 0, 8'h00); op(0, 0, 8'h00); op(0, 0, 8'h00);
  endtask

  // Both ports push every cycle; grants must alternate starting with A.
  task automatic test_alternate();
    logic want_a;
    test_reset();
    want_a = 1;
    a_req = 1; a_push = 1; b_req = 1; b_push = 1;
    for (int i = 0; i < 8; i++) begin
      a_wdata = 8'hA0 + 8'(i); b_wdata = 8'hB0 + 8'(i);
      #1;
      total++;
      if (a_gnt !== want_a || b_gnt !== !want_a) begin
        bad++; $display("FAIL alt_gnt cyc=%0d got a=%b b=%b want a=%b", i, a_gnt, b_gnt, want_a);
      end
      model.push_back(want_a ? a_wdata : b_wdata);
      want_a = !want_a;
      @(posedge myclock);
      @(negedge myclock);
      total++;
      if (count !== 5'(i + 1)) begin bad++; $display("FAIL alt_count cyc=%0d got=%0d want=%0d", i, count, i + 1); end
    end
    a_req = 0; b_req = 0;
    repeat (8) op(1, 0, 8'h00);
  endtask

  task automatic test_full();
    for (int i = 0; i < DEPTH; i++) op(0, 1, 8'(i * 7 + 3));
    op(0, 1, 8'hEE);
    repeat (DEPTH) op(1, 0, 8'h00);
  endtask

  task automatic test_empty_wrap();
    op(0, 0, 8'h00);
    for (int i = 0; i < 20; i++) begin
      op(1, 1, 8'h40 + 8'(i));
      op(0, 0, 8'h00);
    end
  endtask

  task automatic test_hold();
    hold = 1; a_req = 1; a_push = 1; a_wdata = 8'h5A;
    for (int i = 0; i < 3; i++) begin
      #1;
      total++;
      if (a_gnt !== 1'b0) begin bad++; $display("FAIL hold_gnt cyc=%0d got=%b want=0", i, a_gnt); end
      @(negedge myclock);
    end
    hold = 0;
    #1;
    total++;
    if (a_gnt !== 1'b0) begin bad++; $display("FAIL hold_exit_gnt got=%b want=0", a_gnt); end
    @(negedge myclock);
    #1;
    total++;
    if (a_gnt !== 1'b1) begin bad++; $display("FAIL hold_resume_gnt got=%b want=1", a_gnt); end
    if (a_gnt === 1'b1) model.push_back(8'h5A);
    @(posedge myclock);
    @(negedge myclock);
    a_req = 0;
    total++;
    if (count !== 5'(model.size())) begin bad++; $display("FAIL hold_count got=%0d want=%0d", count, model.size()); end
    while (model.size() > 0) op(0, 0, 8'h00);
  endtask

  task automatic test_flush();
    for (int i = 0; i < DEPTH; i++) op(0, 1, 8'hC0 + 8'(i));
    op(1, 1, 8'hFF);
    repeat (DEPTH - 5) op(0, 0, 8'h00);
    b_req = 1; b_push = 0; flush = 1;
    #1;
    total++;
    if (b_gnt !== 1'b0) begin bad++; $display("FAIL flush_gnt got=%b want=0", b_gnt); end
    @(posedge myclock);
    @(negedge myclock);
    flush = 0;
    model.delete(); ovf_exp = 0; unf_exp = 0;
    #1;
    total++;
    if ({count, empty, ovf_sticky, unf_sticky, b_err, b_rvalid} !== {5'd0, 1'b1, 4'b0}) begin
      bad++; $display("FAIL flush_state got cnt=%0d e=%b o=%b u=%b err=%b rv=%b", count, empty, ovf_sticky, unf_sticky, b_err, b_rvalid);
    end
    total++;
    if (b_gnt !== 1'b0) begin bad++; $display("FAIL flush_cycle_gnt got=%b want=0", b_gnt); end
    b_req = 0;
    @(negedge myclock);
    op(1, 0, 8'h00);
    total++;
    if (exp_q.size() != 0) begin bad++; $display("FAIL sb_leftover got=%0d want=0", exp_q.size()); end
  endtask

  initial begin
    total = 0; bad = 0;
    resetn = 1; hold = 0; flush = 0;
    a_req = 0; a_push = 0; a_wdata = '0;
    b_req = 0; b_push = 0; b_wdata = '0;
    test_reset();
    test_basic();
    test_alternate();
    test_full();
    test_empty_wrap();
    test_hold();
    test_flush();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
